// File: rtl/battle_round_ctrl.sv
// Per-frame combat sequencer: starts a damage summation, waits for the result,
// applies both totals to the base HP values with saturation and detects game end.
module battle_round_ctrl #(
    parameter int P_MAX_HP  = 1000,
    parameter int P_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frameTick,
    input  logic        newGame,
    input  logic        calcDone,
    input  logic [11:0] totalUnitDamage,
    input  logic [11:0] totalEnemyDamage,
    output logic        calcStart,
    output logic        calcAck,
    output logic [11:0] playerHP,
    output logic [11:0] enemyHP,
    output logic [7:0]  roundCount,
    output logic        gameOver,
    output logic        playerWon,
    output logic        overrun,
    output logic        calcErr
);

    localparam int CW = (P_TIMEOUT > 1) ? $clog2(P_TIMEOUT) : 1;
    localparam logic [11:0]   MAX_HP    = 12'(P_MAX_HP);
    localparam logic [CW-1:0] WAIT_LAST = CW'(P_TIMEOUT - 1);

    typedef enum logic [6:0] {
        IDLE  = 7'b0000001,
        START = 7'b0000010,
        WAIT  = 7'b0000100,
        APPLY = 7'b0001000,
        ACK   = 7'b0010000,
        CHECK = 7'b0100000,
        OVER  = 7'b1000000
    } stateType;

    stateType       state, nextState;
    logic [CW-1:0]  waitCnt;
    logic [11:0]    unitDmgLatched, enemyDmgLatched;
    logic           anyZero;

    assign anyZero   = (playerHP == 12'd0) || (enemyHP == 12'd0);
    assign calcStart = (state == START);
    assign calcAck   = (state == ACK);
    assign gameOver  = (state == OVER);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Any code outside the seven one-hot values falls back to IDLE.
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (!newGame && frameTick) nextState = START;
            START:   nextState = WAIT;
            WAIT: begin
                if (calcDone)                  nextState = APPLY;
                else if (waitCnt == WAIT_LAST) nextState = IDLE;
            end
            APPLY:   nextState = ACK;
            ACK:     nextState = CHECK;
            CHECK:   nextState = anyZero ? OVER : IDLE;
            OVER:    if (newGame) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Totals are captured on Done so the datapath may drop them before APPLY.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            playerHP        <= MAX_HP;
            enemyHP         <= MAX_HP;
            roundCount      <= 8'd0;
            waitCnt         <= '0;
            playerWon       <= 1'b0;
            overrun         <= 1'b0;
            calcErr         <= 1'b0;
            unitDmgLatched  <= 12'd0;
            enemyDmgLatched <= 12'd0;
        end else begin
            if (frameTick && (state != IDLE) && (state != OVER)) begin
                overrun <= 1'b1;
            end
            case (state)
                IDLE, OVER: begin
                    if (newGame) begin
                        playerHP   <= MAX_HP;
                        enemyHP    <= MAX_HP;
                        roundCount <= 8'd0;
                        overrun    <= 1'b0;
                        calcErr    <= 1'b0;
                        playerWon  <= 1'b0;
                    end
                end
                START: waitCnt <= '0;
                WAIT: begin
                    if (calcDone) begin
                        unitDmgLatched  <= totalUnitDamage;
                        enemyDmgLatched <= totalEnemyDamage;
                    end else begin
                        waitCnt <= waitCnt + 1'b1;
                        if (waitCnt == WAIT_LAST) calcErr <= 1'b1;
                    end
                end
                APPLY: begin
                    enemyHP  <= (enemyHP  > unitDmgLatched)  ? enemyHP  - unitDmgLatched  : 12'd0;
                    playerHP <= (playerHP > enemyDmgLatched) ? playerHP - enemyDmgLatched : 12'd0;
                    if (roundCount != 8'd255) roundCount <= roundCount + 8'd1;
                end
                CHECK: begin
                    if (anyZero) playerWon <= (enemyHP == 12'd0) && (playerHP != 12'd0);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_battle_round_ctrl.sv
// Self-checking bench for battle_round_ctrl: directed scenarios plus randomized
// rounds compared against a round-level HP/score model.
module tb_battle_round_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        frameTick, newGame, calcDone;
    logic [11:0] totalUnitDamage, totalEnemyDamage;
    logic        calcStart, calcAck;
    logic [11:0] playerHP, enemyHP;
    logic [7:0]  roundCount;
    logic        gameOver, playerWon, overrun, calcErr;

    int checks = 0;
    int failures = 0;
    int startCount = 0;
    int ackCount = 0;

    // Game-level reference state
    int  mPlayer, mEnemy, mRounds;
    bit  mOverrun, mErr, mOver, mWon;

    battle_round_ctrl #(.P_MAX_HP(1000), .P_TIMEOUT(64)) dut (
        .clk(clk), .rst(rst), .frameTick(frameTick), .newGame(newGame),
        .calcDone(calcDone), .totalUnitDamage(totalUnitDamage),
        .totalEnemyDamage(totalEnemyDamage), .calcStart(calcStart),
        .calcAck(calcAck), .playerHP(playerHP), .enemyHP(enemyHP),
        .roundCount(roundCount), .gameOver(gameOver), .playerWon(playerWon),
        .overrun(overrun), .calcErr(calcErr)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            startCount += int'(calcStart);
            ackCount   += int'(calcAck);
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] simulation did not finish");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic modelReinit();
        mPlayer = 1000; mEnemy = 1000; mRounds = 0;
        mOverrun = 0; mErr = 0; mOver = 0; mWon = 0;
    endtask

    task automatic checkStatus(input string tag);
        checkOutput({tag, ".playerHP"},   32'(playerHP),   32'(mPlayer));
        checkOutput({tag, ".enemyHP"},    32'(enemyHP),    32'(mEnemy));
        checkOutput({tag, ".roundCount"}, 32'(roundCount), 32'(mRounds));
        checkOutput({tag, ".overrun"},    32'(overrun),    32'(mOverrun));
        checkOutput({tag, ".calcErr"},    32'(calcErr),    32'(mErr));
        checkOutput({tag, ".gameOver"},   32'(gameOver),   32'(mOver));
        if (mOver) checkOutput({tag, ".playerWon"}, 32'(playerWon), 32'(mWon));
    endtask

    task automatic applyStimulus(input int unitD, input int enemyD, input int delay,
                                 input bit extraTick, input bit holdNew);
        int s0, a0;
        s0 = startCount; a0 = ackCount;
        @(negedge clk); frameTick = 1'b1;
        @(negedge clk); frameTick = 1'b0;
        checkOutput("round.calcStart", 32'(calcStart), 32'd1);
        newGame = holdNew;
        for (int i = 0; i <= delay; i++) begin
            @(negedge clk);
            frameTick = extraTick && (i == 0);
            if (i == delay) begin
                calcDone = 1'b1;
                totalUnitDamage  = 12'(unitD);
                totalEnemyDamage = 12'(enemyD);
            end
        end
        @(negedge clk);
        frameTick = 1'b0; calcDone = 1'b0;
        @(negedge clk);
        mEnemy  = (mEnemy  > unitD)  ? mEnemy  - unitD  : 0;
        mPlayer = (mPlayer > enemyD) ? mPlayer - enemyD : 0;
        mRounds = (mRounds < 255) ? mRounds + 1 : 255;
        if (extraTick) mOverrun = 1;
        checkOutput("round.calcAck", 32'(calcAck), 32'd1);
        checkOutput("round.ackHP.player", 32'(playerHP), 32'(mPlayer));
        checkOutput("round.ackHP.enemy", 32'(enemyHP), 32'(mEnemy));
        totalUnitDamage = 12'd0; totalEnemyDamage = 12'd0;
        newGame = 1'b0;
        @(negedge clk);
        @(negedge clk);
        mOver = (mPlayer == 0) || (mEnemy == 0);
        mWon  = (mEnemy == 0) && (mPlayer != 0);
        checkStatus("round");
        checkOutput("round.startPulses", 32'(startCount - s0), 32'd1);
        checkOutput("round.ackPulses", 32'(ackCount - a0), 32'd1);
    endtask

    task automatic doNewGame();
        @(negedge clk); newGame = 1'b1;
        @(negedge clk); newGame = 1'b0;
        modelReinit();
        checkStatus("newGame");
        checkOutput("newGame.playerWon", 32'(playerWon), 32'd0);
    endtask

    task automatic tickInOver();
        int s0;
        s0 = startCount;
        @(negedge clk); frameTick = 1'b1;
        @(negedge clk); frameTick = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("over.noStart", 32'(startCount - s0), 32'd0);
        checkOutput("over.gameOver", 32'(gameOver), 32'd1);
        checkOutput("over.overrun", 32'(overrun), 32'(mOverrun));
    endtask

    task automatic doTimeout();
        int a0;
        a0 = ackCount;
        @(negedge clk); frameTick = 1'b1;
        @(negedge clk); frameTick = 1'b0;
        repeat (64) @(negedge clk);
        checkOutput("timeout.errBeforeLast", 32'(calcErr), 32'(mErr));
        @(negedge clk);
        mErr = 1;
        checkStatus("timeout");
        checkOutput("timeout.noAck", 32'(ackCount - a0), 32'd0);
    endtask

    initial begin
        rst = 1'b1; frameTick = 1'b0; newGame = 1'b0; calcDone = 1'b0;
        totalUnitDamage = 12'd0; totalEnemyDamage = 12'd0;
        modelReinit();
        #1;
        checkStatus("reset");
        checkOutput("reset.calcStart", 32'(calcStart), 32'd0);
        checkOutput("reset.calcAck", 32'(calcAck), 32'd0);
        checkOutput("reset.playerWon", 32'(playerWon), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        applyStimulus(300, 120, 2, 0, 0);
        applyStimulus(10, 20, 3, 1, 1);
        doNewGame();

        doTimeout();
        applyStimulus(5, 7, 0, 0, 0);
        doNewGame();

        applyStimulus(900, 0, 1, 0, 0);
        applyStimulus(4095, 0, 4, 0, 0);
        tickInOver();
        doNewGame();

        applyStimulus(950, 950, 0, 0, 0);
        applyStimulus(50, 60, 1, 0, 0);
        tickInOver();
        doNewGame();

        // Asynchronous reset while WAITing, checked before any clock edge
        applyStimulus(100, 200, 0, 1, 0);
        @(negedge clk); frameTick = 1'b1;
        @(negedge clk); frameTick = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        modelReinit();
        checkStatus("asyncRst");
        checkOutput("asyncRst.calcStart", 32'(calcStart), 32'd0);
        checkOutput("asyncRst.calcAck", 32'(calcAck), 32'd0);
        @(negedge clk); rst = 1'b0;
        applyStimulus(30, 40, 2, 0, 0);

        for (int n = 0; n < 40; n++) begin
            if (mOver) begin
                tickInOver();
                doNewGame();
            end else if ($urandom_range(0, 9) == 0) begin
                doNewGame();
            end else begin
                applyStimulus($urandom_range(0, 350), $urandom_range(0, 350),
                              $urandom_range(0, 8), ($urandom_range(0, 3) == 0),
                              ($urandom_range(0, 3) == 0));
            end
        end

        doNewGame();
        for (int n = 0; n < 258; n++) applyStimulus(0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
